// File: rtl/piece_writer_pkg.sv
// Shared constants, FSM encoding and block-field helpers for piece_writer.
package piece_writer_pkg;
    localparam int BOARD_W = 10;
    localparam int BOARD_H = 25;
    localparam logic [5:0] EMPTY_CELL = 6'd0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_ISSUE = 3'd1,
        CHK_DRAIN = 3'd2,
        WRITE     = 3'd3,
        FINISH    = 3'd4
    } state_t;

    function automatic logic [3:0] blk_x_of(input logic [15:0] v, input logic [1:0] i);
        return v[4*int'(i) +: 4];
    endfunction

    function automatic logic [4:0] blk_y_of(input logic [19:0] v, input logic [1:0] i);
        return v[5*int'(i) +: 5];
    endfunction
endpackage

// File: rtl/piece_writer_coord_to_addr.sv
// Board cell coordinate to linear RAM address: addr = y*BOARD_W + x.
module coord_to_addr #(
    parameter int BOARD_W = 10
) (
    input  logic [3:0] x,
    input  logic [4:0] y,
    output logic [7:0] addr
);
    assign addr = 8'(y) * 8'(BOARD_W) + 8'(x);
endmodule

// File: rtl/piece_writer.sv
// Tetromino board-RAM client: collision check (read) and place (write) of four cells.
// PIECE_WRITER_SAFE_PLACE_EN makes place mode run a check first and skip the write on collision.
module piece_writer
    import piece_writer_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [15:0] blk_x,
    input  logic [19:0] blk_y,
    input  logic [5:0]  colour,
    input  logic [5:0]  ram_Q,
    output logic [7:0]  ram_addr,
    output logic [5:0]  ram_data,
    output logic        ram_wren,
    output logic        busy,
    output logic        done,
    output logic        collision
);
`ifdef PIECE_WRITER_SAFE_PLACE_EN
    localparam bit SAFE_PLACE = 1'b1;
`else
    localparam bit SAFE_PLACE = 1'b0;
`endif

    state_t            state, state_n;
    logic [3:0]        idx, idx_n;
    logic [15:0]       x_q;
    logic [19:0]       y_q;
    logic [5:0]        colour_q;
    logic              mode_q;
    logic [RD_LAT-1:0] vld;
    logic              coll_n;
    logic              issue;
    logic [3:0]        cur_x;
    logic [4:0]        cur_y;
    logic [7:0]        cur_addr;
    logic              cur_oob;

    assign cur_x   = blk_x_of(x_q, idx[1:0]);
    assign cur_y   = blk_y_of(y_q, idx[1:0]);
    assign cur_oob = (cur_x >= 4'(BOARD_W)) || (cur_y >= 5'(BOARD_H));
    assign issue   = (state == CHK_ISSUE) && !cur_oob;

    coord_to_addr #(.BOARD_W(BOARD_W)) u_coord_to_addr (
        .x    (cur_x),
        .y    (cur_y),
        .addr (cur_addr)
    );

    // RAM port is combinational so the address lands in the same cycle as the state.
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_wren = 1'b0;
        case (state)
            CHK_ISSUE: ram_addr = cur_oob ? 8'd0 : cur_addr;
            WRITE: begin
                ram_addr = cur_oob ? 8'd0 : cur_addr;
                ram_data = colour_q;
                ram_wren = !cur_oob;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        coll_n  = collision;
        // vld only carries in-bounds reads, so OOB return data never reaches here.
        if (vld[RD_LAT-1] && (ram_Q != EMPTY_CELL))
            coll_n = 1'b1;
        case (state)
            IDLE: begin
                if (start) begin
                    coll_n  = 1'b0;
                    idx_n   = '0;
                    state_n = (mode && !SAFE_PLACE) ? WRITE : CHK_ISSUE;
                end
            end
            CHK_ISSUE: begin
                if (cur_oob)
                    coll_n = 1'b1;
                idx_n = idx + 4'd1;
                if (idx[1:0] == 2'd3) begin
                    idx_n   = '0;
                    state_n = CHK_DRAIN;
                end
            end
            CHK_DRAIN: begin
                idx_n = idx + 4'd1;
                if (idx == 4'(RD_LAT - 1)) begin
                    idx_n   = '0;
                    state_n = (SAFE_PLACE && mode_q && !coll_n) ? WRITE : FINISH;
                end
            end
            WRITE: begin
                idx_n = idx + 4'd1;
                if (idx[1:0] == 2'd3) begin
                    idx_n   = '0;
                    state_n = FINISH;
                end
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            vld       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            mode_q    <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            vld       <= (vld << 1) | RD_LAT'(issue);
            busy      <= (state_n != IDLE);
            done      <= (state == FINISH);
            collision <= coll_n;
            if ((state == IDLE) && start) begin
                x_q      <= blk_x;
                y_q      <= blk_y;
                colour_q <= colour;
                mode_q   <= mode;
            end
        end
    end
endmodule

// File: tb/tb_piece_writer.sv
// Scoreboard bench for piece_writer: directed check/place operations against a 2-cycle board RAM model.
module tb_piece_writer;
`ifdef PIECE_WRITER_SAFE_PLACE_EN
    localparam bit SAFE = 1'b1;
`else
    localparam bit SAFE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] blk_x = '0;
    logic [19:0] blk_y = '0;
    logic [5:0]  colour = '0;
    logic [5:0]  ram_Q;
    logic [7:0]  ram_addr;
    logic [5:0]  ram_data;
    logic        ram_wren;
    logic        busy;
    logic        done;
    logic        collision;

    int checks = 0;
    int errors = 0;

    // clock / reset
    always #5 clk = ~clk;

    piece_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .blk_x     (blk_x),
        .blk_y     (blk_y),
        .colour    (colour),
        .ram_Q     (ram_Q),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_wren  (ram_wren),
        .busy      (busy),
        .done      (done),
        .collision (collision)
    );

    // board RAM model, 2-cycle read latency
    logic [5:0] mem [256];
    logic [5:0] q1, q2;
    logic       clr = 1'b0;
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0;
    logic [5:0] pl_data = '0;

    always @(posedge clk) begin
        q1 <= mem[ram_addr];
        q2 <= q1;
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (pl_en) mem[pl_addr] <= pl_data;
            if (ram_wren) mem[ram_addr] <= ram_data;
        end
    end
    assign ram_Q = q2;

    // cycle offset from the accepted start edge
    logic accept = 1'b0;
    int   off = 1000;
    always @(posedge clk) begin
        if (start && accept) off <= 0;
        else if (off < 1000) off <= off + 1;
    end

    // scoreboard
    logic [13:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [8:0]  exp_q[$];
    int done_seen = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        logic [13:0] w;
        logic [8:0]  r;
        if (!reset) begin
            if (ram_wren) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %0d expected no write", ram_addr, ram_data);
                end else begin
                    w = wr_q.pop_front();
                    chk("write_addr", int'(ram_addr), int'(w[13:6]));
                    chk("write_data", int'(ram_data), int'(w[5:0]));
                end
            end else if (off <= 3 && rd_q.size() > 0) begin
                chk("read_addr", int'(ram_addr), int'(rd_q.pop_front()));
            end
            if (off == 0) chk("busy_after_start", int'(busy), 1);
            if (done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none");
                end else begin
                    r = exp_q.pop_front();
                    chk("collision", int'(collision), int'(r[8]));
                    chk("latency", off, int'(r[7:0]));
                    chk("busy_at_done", int'(busy), 0);
                end
            end
        end
    end

    // driver tasks
    task automatic mem_clear();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic mem_load(input logic [7:0] a, input logic [5:0] d);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic issue(input logic m, input logic [15:0] x, input logic [19:0] y,
                         input logic [5:0] c, input logic acc);
        @(negedge clk);
        mode   = m;
        blk_x  = x;
        blk_y  = y;
        colour = c;
        start  = 1'b1;
        accept = acc;
        @(negedge clk);
        start  = 1'b0;
        accept = 1'b0;
        mode   = ~m;
        blk_x  = ~x;
        blk_y  = ~y;
        colour = c ^ 6'h3F;
    endtask

    task automatic push_cells(input logic m, input logic [15:0] x, input logic [19:0] y,
                              input logic [5:0] c, input logic ec);
        logic [3:0] xi;
        logic [4:0] yi;
        logic       oob;
        logic [7:0] a;
        for (int i = 0; i < 4; i++) begin
            xi  = x[4*i +: 4];
            yi  = y[5*i +: 5];
            oob = (xi >= 4'd10) || (yi >= 5'd25);
            a   = oob ? 8'd0 : 8'(yi) * 8'd10 + 8'(xi);
            if (!m || SAFE) rd_q.push_back(a);
            if (m && !(SAFE && ec) && !oob) wr_q.push_back({a, c});
        end
    endtask

    task automatic run_op(input logic m, input logic [15:0] x, input logic [19:0] y,
                          input logic [5:0] c, input logic ec, input int lat);
        int n;
        push_cells(m, x, y, c, ec);
        exp_q.push_back({ec, 8'(lat)});
        n = done_seen;
        issue(m, x, y, c, 1'b1);
        for (int k = 0; k < 30 && done_seen == n; k++) @(posedge clk);
        if (done_seen == n) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 30 cycles");
            exp_q.delete();
            rd_q.delete();
            wr_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        clr = 1'b1;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        chk("rst_ram_addr", int'(ram_addr), 0);
        chk("rst_ram_data", int'(ram_data), 0);
        chk("rst_ram_wren", int'(ram_wren), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_collision", int'(collision), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // check, empty board: (4,0)(5,0)(4,1)(5,1)
        run_op(1'b0, 16'h5454, {5'd1, 5'd1, 5'd0, 5'd0}, 6'd0, 1'b0, 7);
        // same piece with RAM[15] occupied
        mem_load(8'd15, 6'd3);
        run_op(1'b0, 16'h5454, {5'd1, 5'd1, 5'd0, 5'd0}, 6'd0, 1'b1, 7);
        // x out of bounds: (10,3)(1,0)(2,0)(3,0), addr 0 nonzero
        mem_clear();
        mem_load(8'd0, 6'd7);
        run_op(1'b0, 16'h321A, {5'd0, 5'd0, 5'd0, 5'd3}, 6'd0, 1'b1, 7);
        // collision clears on the next start
        run_op(1'b0, 16'h5454, {5'd1, 5'd1, 5'd0, 5'd0}, 6'd0, 1'b0, 7);
        // y out of bounds: (0,25)(1,1)(2,2)(3,3)
        run_op(1'b0, 16'h3210, {5'd3, 5'd2, 5'd1, 5'd25}, 6'd0, 1'b1, 7);

        // place colour 5 on the bottom row (0..3,24)
        mem_clear();
        run_op(1'b1, 16'h3210, {5'd24, 5'd24, 5'd24, 5'd24}, 6'd5, 1'b0, SAFE ? 11 : 5);
        chk("mem_243_after_place", int'(mem[243]), 5);
        // place onto occupied RAM[243]
        mem_clear();
        mem_load(8'd243, 6'd1);
        run_op(1'b1, 16'h3210, {5'd24, 5'd24, 5'd24, 5'd24}, 6'h2A, SAFE, SAFE ? 7 : 5);
        chk("mem_240_occupied_case", int'(mem[240]), SAFE ? 0 : 42);
        // place with an OOB block and a duplicate: (9,24)(10,0)(0,0)(0,0)
        mem_clear();
        run_op(1'b1, 16'h00A9, {5'd0, 5'd0, 5'd0, 5'd24}, 6'h11, SAFE, SAFE ? 7 : 5);
        chk("mem_0_dup_write", int'(mem[0]), SAFE ? 0 : 17);

        // place aborted by reset during the 2nd WRITE cycle, with a start pulse while busy
        mem_clear();
        if (SAFE) begin
            for (int i = 0; i < 4; i++) rd_q.push_back(8'(240 + i));
        end
        wr_q.push_back({8'd240, 6'd5});
        issue(1'b1, 16'h3210, {5'd24, 5'd24, 5'd24, 5'd24}, 6'd5, 1'b1);
        repeat (SAFE ? 6 : 0) @(negedge clk);
        blk_x  = 16'h5454;
        blk_y  = '0;
        colour = 6'd9;
        mode   = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        start = 1'b0;
        #1;
        chk("abort_ram_wren", int'(ram_wren), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_collision", int'(collision), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_mem_240", int'(mem[240]), 5);
        chk("abort_mem_241", int'(mem[241]), 0);

        // final report
        repeat (4) @(negedge clk);
        chk("pending_writes", wr_q.size(), 0);
        chk("pending_reads", rd_q.size(), 0);
        chk("pending_results", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
